// File: rtl/reorder_buffer.sv
// reorder_buffer: circular ROB that tags issued instructions, collects CDB results and commits in program order
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int ROB_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             in_issue_valid,
  input  logic [4:0]       in_issue_dest_reg,
  input  logic             in_issue_is_branch,
  input  logic             in_issue_pred_taken,
  output logic [ROB_W-1:0] out_issue_rob,
  output logic             out_full,
  input  logic             in_cdb_valid,
  input  logic [ROB_W-1:0] in_cdb_rob,
  input  logic [31:0]      in_cdb_value,
  input  logic             in_cdb_taken,
  input  logic [31:0]      in_cdb_next_pc,
  input  logic [ROB_W-1:0] in_query1_rob,
  input  logic [ROB_W-1:0] in_query2_rob,
  output logic             out_query1_ready,
  output logic             out_query2_ready,
  output logic [31:0]      out_query1_value,
  output logic [31:0]      out_query2_value,
  output logic [4:0]       out_commit_reg,
  output logic [ROB_W-1:0] out_commit_rob,
  output logic [31:0]      out_commit_value,
  output logic             out_xbp,
  output logic [31:0]      out_xbp_pc
);
  logic [ROB_W-1:0]    head, tail;
  logic [ROB_W:0]      count;
  logic [ROB_SIZE-1:0] busy, done, is_br, pred, tkn;
  logic [4:0]          dest [ROB_SIZE];
  logic [31:0]         val  [ROB_SIZE];
  logic [31:0]         npc  [ROB_SIZE];
  logic                can_commit, flush, commit, do_issue, do_cdb, hit1, hit2;

  assign out_issue_rob    = tail;
  assign out_full         = count == (ROB_W+1)'(ROB_SIZE);
  assign can_commit       = count != '0 && done[head];
  assign flush            = can_commit && is_br[head] && tkn[head] != pred[head];
  assign commit           = can_commit && !flush;
  assign do_issue         = in_issue_valid && !out_full;
  assign do_cdb           = in_cdb_valid && busy[in_cdb_rob];
  assign hit1             = in_cdb_valid && in_cdb_rob == in_query1_rob && busy[in_query1_rob];
  assign hit2             = in_cdb_valid && in_cdb_rob == in_query2_rob && busy[in_query2_rob];
  assign out_query1_ready = done[in_query1_rob] | hit1;
  assign out_query2_ready = done[in_query2_rob] | hit2;
  assign out_query1_value = hit1 ? in_cdb_value : val[in_query1_rob];
  assign out_query2_value = hit2 ? in_cdb_value : val[in_query2_rob];

  // Allocation, result capture, in-order retirement and misprediction flush
  always_ff @(posedge clk) begin
    if (rst) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      busy             <= '0;
      done             <= '0;
      out_commit_reg   <= '0;
      out_commit_rob   <= '0;
      out_commit_value <= '0;
      out_xbp          <= 1'b0;
      out_xbp_pc       <= '0;
    end else if (rdy) begin
      out_commit_reg   <= (commit && !is_br[head]) ? dest[head] : 5'd0;
      out_commit_rob   <= head;
      out_commit_value <= commit ? val[head] : 32'd0;
      out_xbp          <= flush;
      out_xbp_pc       <= flush ? npc[head] : 32'd0;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
        done  <= '0;
      end else begin
        if (do_cdb) begin
          done[in_cdb_rob] <= 1'b1;
          val[in_cdb_rob]  <= in_cdb_value;
          tkn[in_cdb_rob]  <= in_cdb_taken;
          npc[in_cdb_rob]  <= in_cdb_next_pc;
        end
        if (do_issue) begin
          busy[tail]  <= 1'b1;
          done[tail]  <= 1'b0;
          dest[tail]  <= in_issue_dest_reg;
          is_br[tail] <= in_issue_is_branch;
          pred[tail]  <= in_issue_pred_taken;
          tail        <= tail + 1'b1;
        end
        if (commit) begin
          busy[head] <= 1'b0;
          done[head] <= 1'b0;
          head       <= head + 1'b1;
        end
        count <= count + (ROB_W+1)'(do_issue) - (ROB_W+1)'(commit);
      end
    end
  end
endmodule
